// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-side FSM encoding and default geometry.
// Imported by both the write side and the read side of the FIFO.
package fifo_pkg;

  localparam int FIFO_ADDR_W = 2;
  localparam int FIFO_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_PRESENT = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Binary FIFO pointer with one extra wrap bit and increment enable.
// Shared by the write-side and read-side controllers.
module fifo_ptr_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  assign ptr_d = inc_i ? ptr_q + W'(1) : ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_read_ctrl.sv
// FIFO read-side controller: read pointer, RAM read port, registered output.
// Define FIFO_RD_LEVEL_EN to add the registered occupancy output 'level'.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int DATA_W = FIFO_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W:0]   wr_ptr,
  output logic [ADDR_W:0]   rd_ptr,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              empty
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [ADDR_W:0]   level
`endif
);

  rd_state_e         state_q;
  logic [DATA_W-1:0] dout_q;
  logic              valid_q;
  logic              mem_empty;
  logic              is_idle;
  logic              is_wait;
  logic              is_pres;
  logic              rd_inc;

  assign mem_empty = (rd_ptr == wr_ptr);
  assign is_idle   = (state_q == ST_IDLE);
  assign is_wait   = (state_q == ST_WAIT);
  assign is_pres   = (state_q == ST_PRESENT);

  // A read is issued from IDLE, or back-to-back on a PRESENT handshake.
  assign rd_inc = !mem_empty &&
                  (is_idle || (is_pres && dout_ready));

  fifo_ptr_cnt #(
    .W (ADDR_W + 1)
  ) u_rd_ptr (
    .clk   (clk),
    .rst_n (reset),
    .inc_i (rd_inc),
    .ptr_o (rd_ptr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (1'b1)
        is_idle: begin
          if (!mem_empty) state_q <= ST_WAIT;
        end
        is_wait: begin
          dout_q  <= mem_rdata;
          valid_q <= 1'b1;
          state_q <= ST_PRESENT;
        end
        is_pres: begin
          if (dout_ready) begin
            valid_q <= 1'b0;
            state_q <= mem_empty ? ST_IDLE : ST_WAIT;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_ren    = rd_inc;
  assign mem_raddr  = rd_ptr[ADDR_W-1:0];
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign empty      = mem_empty && is_idle;

`ifdef FIFO_RD_LEVEL_EN
  logic [ADDR_W:0] level_q;
  logic [ADDR_W:0] level_d;

  // A word in flight or held on dout still counts as stored.
  assign level_d = (wr_ptr - rd_ptr) +
                   {{ADDR_W{1'b0}}, !is_idle};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) level_q <= '0;
    else        level_q <= level_d;
  end

  assign level = level_q;
`endif

endmodule
